byte_stream_packer: RTL and testbench
=====================================

BYTE_STREAM_PACKER -- requirements
Module: byte_stream_packer

Interface
REQ-001 SHALL have parameter N_BYTES, default 4: bytes per output word.
REQ-002 SHALL have parameter N_BITS, default N_BYTES*8: output word width.
REQ-003 SHALL have port CLK, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port nRST, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port byte_in, input, 8: upstream byte data.
REQ-006 SHALL have port byte_valid, input, 1: byte_in is valid.
REQ-007 SHALL have port byte_ready, output, 1: packer accepts a byte this cycle.
REQ-008 SHALL have port flush, input, 1: emit the partial word now.
REQ-009 SHALL have port word_out, output, N_BITS: packed word, little-endian (first byte in [7:0]); feeds the downstream endian swapper.
REQ-010 SHALL have port word_strb, output, N_BYTES: per-byte valid lanes of word_out.
REQ-011 SHALL have port word_valid, output, 1: word_out/word_strb are valid.
REQ-012 SHALL have port word_ready, input, 1: downstream accepts the word.
REQ-013 SHALL have port busy, output, 1: partial word held or word_valid high.

Function
REQ-014 SHALL treat a byte handshake as byte_valid & byte_ready on a rising edge, and a word handshake as word_valid & word_ready.
REQ-015 SHALL hold an assembly register and a byte count cnt (0..N_BYTES-1); byte k of a word SHALL land in bits [8k+7:8k].
REQ-016 SHALL hold one output register (word_out, word_strb, word_valid); word_valid SHALL stay high with stable data until its word handshake.
REQ-017 SHALL, on a handshake of the byte that completes the word, load the output register next cycle: strb all ones, cnt to 0, assembly cleared.
REQ-018 SHALL drive byte_ready low only when cnt==N_BYTES-1 and word_valid & !word_ready; this path SHALL be combinational from word_ready.
REQ-019 SHALL, if the output register drains in the same cycle a word completes, load the new word with word_valid staying high (zero-bubble throughput, one word per N_BYTES cycles).
REQ-020 SHALL, on flush with cnt>0 (counting any byte handshaken that cycle), move the partial word out: unfilled lanes zero, strb low for those lanes, cnt to 0.
REQ-021 SHALL, on flush while the output register is full and not draining, hold flush pending internally and execute it on the first cycle the register frees; bytes SHALL not be accepted while a flush is pending.
REQ-022 SHALL treat flush with cnt==0 and no byte handshake as a no-op (no empty word emitted).
REQ-023 SHALL, when flush coincides with the byte completing a word, emit that full word once only (strb all ones).
REQ-024 SHALL drive busy = (cnt!=0) | word_valid | flush_pending.
REQ-025 SHALL add latency of exactly one cycle from the completing byte handshake (or executed flush) to word_valid.

Reset
REQ-026 SHALL, on nRST low, asynchronously clear cnt, assembly register, flush_pending, word_out=0, word_strb=0, word_valid=0; byte_ready=1 and busy=0 after reset.
REQ-027 SHALL, on reset mid-word, discard the partial word and any pending output word without emitting it.

Structure
REQ-028 SHALL take the word-size constant from the shared rv32i_types_pkg package; no new package types.
REQ-029 SHALL be a single module without sub-modules; endian conversion SHALL remain in the downstream endian_swapper, not duplicated here.
REQ-030 SHALL be synthesizable for any N_BYTES>=2, with cnt width $clog2(N_BYTES).

Verification
REQ-031 Bytes 0x11,0x22,0x33,0x44 back-to-back, word_ready=1 -> word_out=0x44332211, strb=4'b1111, word_valid one cycle after the 4th byte.
REQ-032 Continuous stream of 12 bytes, word_ready=1 -> three words, no bubbles, byte_ready constantly 1.
REQ-033 Bytes 0xAA,0xBB then flush -> word_out=0x0000BBAA, strb=4'b0011; flush with cnt==0 -> no word.
REQ-034 word_ready=0 with word pending, send 4 more bytes -> 4th byte stalled (byte_ready=0) until word_ready=1, then both words in order, none lost.
REQ-035 Flush while output full and word_ready=0 -> byte_ready=0 until drained; partial word then emitted with correct strb.
REQ-036 nRST pulsed after 2 bytes and with word_valid=1 -> all outputs zero, busy=0, next 4 bytes form a clean word.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core constants used by the datapath blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rv32i_types_pkg;

   localparam int XLEN       = 32;
   localparam int XLEN_BYTES = XLEN / 8;

endpackage

// File: rtl/byte_stream_packer.sv
// Packs a byte stream into little-endian words with per-lane strobes; flush emits a partial word.
// Latency: one cycle from the completing byte (or executed flush) to word_valid.
// Backpressure: byte_ready drops only on the completing byte while the output word is stalled, or while a flush waits.
module byte_stream_packer
   import rv32i_types_pkg::*;
#(
   parameter int N_BYTES = XLEN_BYTES,
   parameter int N_BITS  = N_BYTES * 8
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   input  logic               flush,
   output logic [N_BITS-1:0]  word_out,
   output logic [N_BYTES-1:0] word_strb,
   output logic               word_valid,
   input  logic               word_ready,
   output logic               busy
);

   localparam int            CW   = $clog2(N_BYTES);
   localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);

   // assembly state
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N_BITS-1:0]  asm_q, asm_d;
   logic               pend_q, pend_d;

   // output register
   logic [N_BITS-1:0]  wout_q, wout_d;
   logic [N_BYTES-1:0] wstrb_q, wstrb_d;
   logic               wvld_q, wvld_d;

   // datapath helpers
   logic               byte_hs;
   logic               out_free;
   logic               complete;
   logic               flush_req;
   logic [CW:0]        cnt_inc;
   logic [N_BITS-1:0]  asm_fill;
   logic [N_BYTES-1:0] fill_strb;

   // Stall only the byte that would need the output register while it is stuck,
   // and everything while a deferred flush waits; word_ready feeds straight through.
   always_comb begin
      byte_ready = !pend_q && !((cnt_q == LAST) && wvld_q && !word_ready);
   end

   // Merge this cycle's byte into the assembly image and work out the resulting lane count.
   always_comb begin
      byte_hs   = byte_valid & byte_ready;
      out_free  = !wvld_q | word_ready;
      flush_req = flush | pend_q;
      complete  = byte_hs && (cnt_q == LAST);
      cnt_inc   = {1'b0, cnt_q} + (CW + 1)'(byte_hs);
      asm_fill  = asm_q;
      for (int k = 0; k < N_BYTES; k++) begin
         if (byte_hs && (cnt_q == CW'(k))) begin
            asm_fill[8*k +: 8] = byte_in;
         end
      end
      fill_strb = '0;
      for (int k = 0; k < N_BYTES; k++) begin
         fill_strb[k] = (cnt_inc > (CW + 1)'(k));
      end
   end

   // Decide what moves into the output register: a completed word wins over a flush,
   // a flush with no bytes held is dropped, and a flush that cannot move yet is parked.
   always_comb begin
      cnt_d   = cnt_inc[CW-1:0];
      asm_d   = asm_fill;
      pend_d  = pend_q;
      wout_d  = wout_q;
      wstrb_d = wstrb_q;
      wvld_d  = wvld_q & !word_ready;
      if (complete) begin
         // byte_ready guarantees the output register is free here
         wout_d  = asm_fill;
         wstrb_d = '1;
         wvld_d  = 1'b1;
         cnt_d   = '0;
         asm_d   = '0;
         pend_d  = 1'b0;
      end else if (flush_req && (cnt_inc != '0)) begin
         if (out_free) begin
            // unfilled lanes are already zero because the assembly clears on every emit
            wout_d  = asm_fill;
            wstrb_d = fill_strb;
            wvld_d  = 1'b1;
            cnt_d   = '0;
            asm_d   = '0;
            pend_d  = 1'b0;
         end else begin
            pend_d  = 1'b1;
         end
      end else if (flush_req) begin
         pend_d = 1'b0;
      end
   end

   // State registers; reset drops any partial or pending word without emitting it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         pend_q  <= 1'b0;
         wout_q  <= '0;
         wstrb_q <= '0;
         wvld_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         pend_q  <= pend_d;
         wout_q  <= wout_d;
         wstrb_q <= wstrb_d;
         wvld_q  <= wvld_d;
      end
   end

   // Output drive straight from the output register.
   always_comb begin
      word_out   = wout_q;
      word_strb  = wstrb_q;
      word_valid = wvld_q;
      busy       = (cnt_q != '0) | wvld_q | pend_q;
   end

endmodule

// File: tb/tb_byte_stream_packer.sv
// Directed bench for byte_stream_packer with 4-byte words.
// Latency: checks word_valid one cycle after the completing byte or executed flush.
// Backpressure: exercises word_ready stalls and deferred flush.
module tb_byte_stream_packer;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        flush;
   logic [31:0] word_out;
   logic [3:0]  word_strb;
   logic        word_valid;
   logic        word_ready;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   byte_stream_packer #(.N_BYTES(4)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .flush      (flush),
      .word_out   (word_out),
      .word_strb  (word_strb),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   // advance one clock and settle just past the edge
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // present one byte for one cycle
   task automatic drv_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_in    = b;
      cyc();
      byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0; word_ready = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", word_valid); end
      checks++; if (word_out !== 32'h0) begin failures++; $display("FAIL rst_word got=%h exp=00000000", word_out); end
      checks++; if (word_strb !== 4'h0) begin failures++; $display("FAIL rst_strb got=%b exp=0000", word_strb); end
      checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", byte_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      cyc();
      nRST = 1'b1;
      cyc();
   endtask

   task automatic test_single_word();
      logic [7:0] b [4];
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      word_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         byte_valid = 1'b1; byte_in = b[i];
         @(negedge CLK);
         checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL sw_ready[%0d] got=%0b exp=1", i, byte_ready); end
         checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL sw_early[%0d] got=%0b exp=0", i, word_valid); end
         cyc();
      end
      byte_valid = 1'b0;
      @(negedge CLK);
      checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL sw_valid got=%0b exp=1", word_valid); end
      checks++; if (word_out !== 32'h44332211) begin failures++; $display("FAIL sw_word got=%h exp=44332211", word_out); end
      checks++; if (word_strb !== 4'b1111) begin failures++; $display("FAIL sw_strb got=%b exp=1111", word_strb); end
      cyc();
      @(negedge CLK);
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL sw_drain got=%0b exp=0", word_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sw_busy got=%0b exp=0", busy); end
      cyc();
   endtask

   task automatic test_stream();
      logic [31:0] exp_w;
      logic        exp_v;
      word_ready = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         byte_valid = (i < 12);
         byte_in    = 8'(i + 1);
         exp_v      = (i == 4) || (i == 8) || (i == 12);
         exp_w      = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
         @(negedge CLK);
         if (i < 12) begin
            checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL st_ready[%0d] got=%0b exp=1", i, byte_ready); end
         end
         checks++; if (word_valid !== exp_v) begin failures++; $display("FAIL st_valid[%0d] got=%0b exp=%0b", i, word_valid, exp_v); end
         if (exp_v) begin
            checks++; if (word_out !== exp_w) begin failures++; $display("FAIL st_word[%0d] got=%h exp=%h", i, word_out, exp_w); end
         end
         cyc();
      end
      byte_valid = 1'b0;
      cyc();
   endtask

   task automatic test_flush();
      word_ready = 1'b1;
      drv_byte(8'hAA);
      drv_byte(8'hBB);
      flush = 1'b1; cyc(); flush = 1'b0;
      @(negedge CLK);
      checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL fl_valid got=%0b exp=1", word_valid); end
      checks++; if (word_out !== 32'h0000BBAA) begin failures++; $display("FAIL fl_word got=%h exp=0000bbaa", word_out); end
      checks++; if (word_strb !== 4'b0011) begin failures++; $display("FAIL fl_strb got=%b exp=0011", word_strb); end
      cyc();
      // flush with nothing held must not emit
      flush = 1'b1; cyc(); flush = 1'b0;
      @(negedge CLK);
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL fl_empty got=%0b exp=0", word_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fl_empty_busy got=%0b exp=0", busy); end
      // flush on the completing byte: one full word only
      drv_byte(8'h01); drv_byte(8'h02); drv_byte(8'h03);
      byte_valid = 1'b1; byte_in = 8'h04; flush = 1'b1;
      cyc();
      byte_valid = 1'b0; flush = 1'b0;
      @(negedge CLK);
      checks++; if (word_out !== 32'h04030201) begin failures++; $display("FAIL flc_word got=%h exp=04030201", word_out); end
      checks++; if (word_strb !== 4'b1111) begin failures++; $display("FAIL flc_strb got=%b exp=1111", word_strb); end
      cyc();
      @(negedge CLK);
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL flc_once got=%0b exp=0", word_valid); end
      // flush in the same cycle as a partial byte includes that byte
      drv_byte(8'h5A);
      byte_valid = 1'b1; byte_in = 8'h6B; flush = 1'b1;
      cyc();
      byte_valid = 1'b0; flush = 1'b0;
      @(negedge CLK);
      checks++; if (word_out !== 32'h00006B5A) begin failures++; $display("FAIL flb_word got=%h exp=00006b5a", word_out); end
      checks++; if (word_strb !== 4'b0011) begin failures++; $display("FAIL flb_strb got=%b exp=0011", word_strb); end
      cyc();
      cyc();
   endtask

   task automatic test_back_to_back();
      word_ready = 1'b0;
      drv_byte(8'h01); drv_byte(8'h02); drv_byte(8'h03); drv_byte(8'h04);
      drv_byte(8'h05); drv_byte(8'h06); drv_byte(8'h07);
      byte_valid = 1'b1; byte_in = 8'h08;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL bp_stall[%0d] got=%0b exp=0", i, byte_ready); end
         checks++; if (word_out !== 32'h04030201) begin failures++; $display("FAIL bp_hold[%0d] got=%h exp=04030201", i, word_out); end
         checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_v[%0d] got=%0b exp=1", i, word_valid); end
         cyc();
      end
      word_ready = 1'b1;
      @(negedge CLK);
      checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", byte_ready); end
      cyc();
      byte_valid = 1'b0;
      @(negedge CLK);
      checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL bp_second_v got=%0b exp=1", word_valid); end
      checks++; if (word_out !== 32'h08070605) begin failures++; $display("FAIL bp_second got=%h exp=08070605", word_out); end
      cyc();
      @(negedge CLK);
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL bp_done got=%0b exp=0", word_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy got=%0b exp=0", busy); end
      cyc();
   endtask

   task automatic test_flush_pending();
      word_ready = 1'b0;
      drv_byte(8'h11); drv_byte(8'h22); drv_byte(8'h33); drv_byte(8'h44);
      drv_byte(8'hAA);
      flush = 1'b1; cyc(); flush = 1'b0;
      byte_valid = 1'b1; byte_in = 8'hCC;
      @(negedge CLK);
      checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL fp_ready got=%0b exp=0", byte_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fp_busy got=%0b exp=1", busy); end
      checks++; if (word_out !== 32'h44332211) begin failures++; $display("FAIL fp_hold got=%h exp=44332211", word_out); end
      cyc();
      byte_valid = 1'b0;
      word_ready = 1'b1;
      cyc();
      @(negedge CLK);
      checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL fp_valid got=%0b exp=1", word_valid); end
      checks++; if (word_out !== 32'h000000AA) begin failures++; $display("FAIL fp_word got=%h exp=000000aa", word_out); end
      checks++; if (word_strb !== 4'b0001) begin failures++; $display("FAIL fp_strb got=%b exp=0001", word_strb); end
      checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL fp_ready_after got=%0b exp=1", byte_ready); end
      cyc();
      @(negedge CLK);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fp_idle got=%0b exp=0", busy); end
      cyc();
   endtask

   task automatic test_reset_midword();
      word_ready = 1'b1;
      drv_byte(8'h01); drv_byte(8'h02);
      nRST = 1'b0;
      #2;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0b exp=0", busy); end
      checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%0b exp=1", byte_ready); end
      cyc();
      nRST = 1'b1;
      word_ready = 1'b0;
      drv_byte(8'h01); drv_byte(8'h02); drv_byte(8'h03); drv_byte(8'h04);
      @(negedge CLK);
      checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_v got=%0b exp=1", word_valid); end
      cyc();
      nRST = 1'b0;
      #2;
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0b exp=0", word_valid); end
      checks++; if (word_out !== 32'h0) begin failures++; $display("FAIL rm_word got=%h exp=00000000", word_out); end
      checks++; if (word_strb !== 4'h0) begin failures++; $display("FAIL rm_strb got=%b exp=0000", word_strb); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy2 got=%0b exp=0", busy); end
      cyc();
      nRST = 1'b1;
      word_ready = 1'b1;
      cyc();
      @(negedge CLK);
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL rm_noemit got=%0b exp=0", word_valid); end
      drv_byte(8'hDE); drv_byte(8'hAD); drv_byte(8'hBE); drv_byte(8'hEF);
      @(negedge CLK);
      checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL rm_clean_v got=%0b exp=1", word_valid); end
      checks++; if (word_out !== 32'hEFBEADDE) begin failures++; $display("FAIL rm_clean got=%h exp=efbeadde", word_out); end
      checks++; if (word_strb !== 4'b1111) begin failures++; $display("FAIL rm_clean_strb got=%b exp=1111", word_strb); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_stream();
      test_flush();
      test_back_to_back();
      test_flush_pending();
      test_reset_midword();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
